// File: rtl/ad9361_cal_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad9361_cal_pkg
//  Brief    : Shared types, constants and lane packing helper for the
//             AD9361 rx IODELAY calibration sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package ad9361_cal_pkg;

  localparam int NUM_LANES = 7;
  localparam int TAP_W     = 5;
  localparam int NUM_TAPS  = 32;
  localparam int LEN_W     = TAP_W + 1;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WAIT_LOCK    = 4'd1,
    ST_LOAD         = 4'd2,
    ST_SETTLE       = 4'd3,
    ST_CHECK        = 4'd4,
    ST_NEXT         = 4'd5,
    ST_EVAL         = 4'd6,
    ST_APPLY        = 4'd7,
    ST_APPLY_SETTLE = 4'd8,
    ST_VERIFY       = 4'd9,
    ST_DONE         = 4'd10
  } cal_state_t;

  // Replicate one tap value into every enabled lane slice; disabled lanes stay 0.
  function automatic logic [NUM_LANES*TAP_W-1:0] pack_lanes(
    input logic [TAP_W-1:0]     tap,
    input logic [NUM_LANES-1:0] mask
  );
    logic [NUM_LANES*TAP_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (mask[k]) v[k*TAP_W +: TAP_W] = tap;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad9361_cal_window.sv
`default_nettype none
// ============================================================================
//  Module   : ad9361_cal_window
//  Brief    : Serial scan of the 32-bit pass map, one tap per cycle, that
//             finds the widest contiguous passing window and its centre.
//             Windows do not wrap; ties keep the lowest start.
//  Revision : 1.0  initial release
// ============================================================================
module ad9361_cal_window
  import ad9361_cal_pkg::*;
#(
  parameter logic [TAP_W-1:0] DEFAULT_TAP = 5'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_TAPS-1:0] pass_map,
  output logic [TAP_W-1:0]    best_start,
  output logic [LEN_W-1:0]    best_len,
  output logic [TAP_W-1:0]    centre,
  output logic                done
);

  localparam logic [TAP_W-1:0] c_last_idx = TAP_W'(NUM_TAPS - 1);

  logic             r_active;
  logic             r_done;
  logic [TAP_W-1:0] r_idx;
  logic [TAP_W-1:0] r_run_start;
  logic [LEN_W-1:0] r_run_len;
  logic [TAP_W-1:0] r_best_start;
  logic [LEN_W-1:0] r_best_len;

  logic             w_bit;
  logic [LEN_W-1:0] w_new_len;
  logic [TAP_W-1:0] w_new_start;

  // Extension of the current run if the bit under inspection passes.
  always_comb begin
    w_bit       = pass_map[r_idx];
    w_new_len   = r_run_len + LEN_W'(1);
    w_new_start = (r_run_len == '0) ? r_idx : r_run_start;
  end

  // Walk taps 0..31, tracking the current run and the strictly-longest run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active     <= 1'b0;
      r_done       <= 1'b0;
      r_idx        <= '0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_active     <= 1'b1;
        r_idx        <= '0;
        r_run_start  <= '0;
        r_run_len    <= '0;
        r_best_start <= '0;
        r_best_len   <= '0;
      end else if (r_active) begin
        if (w_bit) begin
          r_run_len   <= w_new_len;
          r_run_start <= w_new_start;
          if (w_new_len > r_best_len) begin
            r_best_len   <= w_new_len;
            r_best_start <= w_new_start;
          end
        end else begin
          r_run_len <= '0;
        end
        if (r_idx == c_last_idx) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_idx <= r_idx + TAP_W'(1);
        end
      end
    end
  end

  // Centre of the best window; an empty map falls back to the default tap.
  always_comb begin
    best_start = r_best_start;
    best_len   = r_best_len;
    done       = r_done;
    if (r_best_len == '0) centre = DEFAULT_TAP;
    else                  centre = r_best_start + TAP_W'(r_best_len >> 1);
  end

endmodule
`default_nettype wire

// File: rtl/ad9361_delay_cal.sv
`default_nettype none
// ============================================================================
//  Module   : ad9361_delay_cal
//  Brief    : Rx IODELAY calibration sequencer for the AD9361 LVDS interface.
//             Sweeps a common tap over all rx lanes, qualifies each tap with
//             adc_valid/adc_status, programs the centre of the widest passing
//             window and verifies it through delay readback.
//  Revision : 1.0  initial release
// ============================================================================
module ad9361_delay_cal
  import ad9361_cal_pkg::*;
#(
  parameter int                     SETTLE_CYCLES  = 16,
  parameter int                     CHECK_SAMPLES  = 256,
  parameter int                     TIMEOUT_CYCLES = 4096,
  parameter logic [TAP_W-1:0]       DEFAULT_TAP    = 5'd0,
  parameter logic [NUM_LANES-1:0]   LANE_MASK      = 7'h7F
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cal_start,
  output logic                         cal_busy,
  output logic                         cal_done,
  output logic                         cal_fail,
  output logic [TAP_W-1:0]             cal_tap,
  output logic [LEN_W-1:0]             cal_width,
  output logic [NUM_TAPS-1:0]          pass_map,
  input  logic                         delay_locked,
  input  logic                         adc_valid,
  input  logic                         adc_status,
  output logic [NUM_LANES-1:0]         up_adc_dld,
  output logic [NUM_LANES*TAP_W-1:0]   up_adc_dwdata,
  input  logic [NUM_LANES*TAP_W-1:0]   up_adc_drdata
);

  localparam int SET_W = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int SMP_W = (CHECK_SAMPLES  > 1) ? $clog2(CHECK_SAMPLES)  : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SET_W-1:0] c_set_last = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] c_smp_last = SMP_W'(CHECK_SAMPLES - 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TAP_W-1:0] c_last_tap = TAP_W'(NUM_TAPS - 1);

  cal_state_t        r_state;
  logic [TAP_W-1:0]  r_tap_cnt;
  logic [SET_W-1:0]  r_settle_cnt;
  logic [SMP_W-1:0]  r_sample_cnt;
  logic [TMO_W-1:0]  r_timeout_cnt;
  logic              r_win_start;

  logic [TAP_W-1:0]     w_unused_best_start;
  logic [LEN_W-1:0]     w_best_len;
  logic [TAP_W-1:0]     w_centre;
  logic                 w_win_done;
  logic [NUM_LANES-1:0] w_lane_bad;
  logic                 w_sweep_state;
  logic                 w_sample_bad;
  logic                 w_timeout;
  logic                 w_pass_last;

  ad9361_cal_window #(
    .DEFAULT_TAP (DEFAULT_TAP)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (r_win_start),
    .pass_map   (pass_map),
    .best_start (w_unused_best_start),
    .best_len   (w_best_len),
    .centre     (w_centre),
    .done       (w_win_done)
  );

  // Per-lane readback mismatch against the programmed tap; unused lanes never flag.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign w_lane_bad[k] = LANE_MASK[k] &&
                           (up_adc_drdata[k*TAP_W +: TAP_W] != cal_tap);
  end

  // Tap qualification terms; a bad sample or timeout outranks a completed pass.
  always_comb begin
    w_sweep_state = (r_state == ST_LOAD)  || (r_state == ST_SETTLE) ||
                    (r_state == ST_CHECK) || (r_state == ST_NEXT);
    w_sample_bad  = adc_valid && !adc_status;
    w_timeout     = (r_timeout_cnt == c_tmo_last);
    w_pass_last   = adc_valid && adc_status && (r_sample_cnt == c_smp_last);
  end

  // Calibration sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tap_cnt     <= '0;
      r_settle_cnt  <= '0;
      r_sample_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_win_start   <= 1'b0;
      cal_busy      <= 1'b0;
      cal_done      <= 1'b0;
      cal_fail      <= 1'b0;
      cal_tap       <= '0;
      cal_width     <= '0;
      pass_map      <= '0;
      up_adc_dld    <= '0;
      up_adc_dwdata <= '0;
    end else begin
      up_adc_dld  <= '0;
      cal_done    <= 1'b0;
      r_win_start <= 1'b0;
      if (w_sweep_state && !delay_locked) begin
        // Lock lost mid-sweep: results so far are meaningless, start over.
        r_state   <= ST_WAIT_LOCK;
        pass_map  <= '0;
        r_tap_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cal_start) begin
              r_state   <= ST_WAIT_LOCK;
              pass_map  <= '0;
              cal_fail  <= 1'b0;
              r_tap_cnt <= '0;
              cal_busy  <= 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (delay_locked) r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            up_adc_dwdata <= pack_lanes(r_tap_cnt, LANE_MASK);
            up_adc_dld    <= LANE_MASK;
            r_settle_cnt  <= '0;
            r_state       <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_settle_cnt == c_set_last) begin
              r_sample_cnt  <= '0;
              r_timeout_cnt <= '0;
              r_state       <= ST_CHECK;
            end else begin
              r_settle_cnt <= r_settle_cnt + SET_W'(1);
            end
          end
          ST_CHECK: begin
            r_timeout_cnt <= r_timeout_cnt + TMO_W'(1);
            if (adc_valid) r_sample_cnt <= r_sample_cnt + SMP_W'(1);
            if (w_sample_bad || w_timeout) begin
              r_state <= ST_NEXT;
            end else if (w_pass_last) begin
              pass_map[r_tap_cnt] <= 1'b1;
              r_state             <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (r_tap_cnt == c_last_tap) begin
              r_win_start <= 1'b1;
              r_state     <= ST_EVAL;
            end else begin
              r_tap_cnt <= r_tap_cnt + TAP_W'(1);
              r_state   <= ST_LOAD;
            end
          end
          ST_EVAL: begin
            if (w_win_done) r_state <= ST_APPLY;
          end
          ST_APPLY: begin
            up_adc_dwdata <= pack_lanes(w_centre, LANE_MASK);
            up_adc_dld    <= LANE_MASK;
            cal_tap       <= w_centre;
            cal_width     <= w_best_len;
            if (w_best_len == '0) cal_fail <= 1'b1;
            r_settle_cnt  <= '0;
            r_state       <= ST_APPLY_SETTLE;
          end
          ST_APPLY_SETTLE: begin
            if (r_settle_cnt == c_set_last) r_state <= ST_VERIFY;
            else                            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
          ST_VERIFY: begin
            if (|w_lane_bad) cal_fail <= 1'b1;
            r_state <= ST_DONE;
          end
          ST_DONE: begin
            cal_done <= 1'b1;
            cal_busy <= 1'b0;
            r_state  <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ad9361_delay_cal.md
Name: ad9361_delay_cal

Overview:
Receive-side IODELAY calibration sequencer for the AD9361 LVDS interface.
- Sweeps a common delay tap, 0..31, across the six rx data lanes and the rx frame lane through the up_adc delay port.
- At each tap, qualifies the link using adc_valid/adc_status and builds a 32-bit pass map.
- Finds the widest contiguous passing window, programs its centre tap and verifies it by readback.
- Sits beside the LVDS interface core. Its clk also drives that core's up_clk.

Parameters:
SETTLE_CYCLES, 16, cycles to wait after each tap load before sampling status
CHECK_SAMPLES, 256, number of adc_valid samples that must all have status=1 for a tap to pass
TIMEOUT_CYCLES, 4096, maximum cycles spent in CHECK; expiry marks the tap as fail
DEFAULT_TAP, 5'd0, tap programmed when no tap passes
LANE_MASK, 7'h7F, lanes driven and verified: bits 0..5 data, bit 6 frame

Ports:
clk  in  1  system clock; also drives up_clk of the interface
rst_n  in  1  asynchronous active-low reset
cal_start  in  1  single-cycle request; accepted only in IDLE
cal_busy  out  1  high from the cycle after acceptance until DONE
cal_done  out  1  single-cycle pulse at completion
cal_fail  out  1  sticky until next accepted start: no pass tap, or readback mismatch
cal_tap  out  5  tap finally programmed
cal_width  out  6  length of the best window, 0..32
pass_map  out  32  bit n = tap n passed
delay_locked  in  1  IDELAYCTRL lock
adc_valid  in  1  receive sample strobe
adc_status  in  1  1 = frame pattern correct
up_adc_dld  out  7  per-lane delay load strobe
up_adc_dwdata  out  35  5 bits per lane; lane k occupies [5k+4:5k]
up_adc_drdata  in  35  delay readback, same packing

Behaviour:
Reset values:
- Outputs: all zero (cal_busy, cal_done, cal_fail, cal_tap, cal_width, pass_map, up_adc_dld, up_adc_dwdata).
- FSM in IDLE.
- A reset mid-calibration abandons it immediately; no delay writes are issued after the reset.

FSM states: IDLE, WAIT_LOCK, LOAD, SETTLE, CHECK, NEXT, EVAL, APPLY, APPLY_SETTLE, VERIFY, DONE.
- IDLE: cal_start=1 → WAIT_LOCK. On that transition clear pass_map, cal_fail and tap_cnt. cal_busy rises the next cycle.
- WAIT_LOCK: delay_locked=1 → LOAD.
- LOAD:
  - Drive up_adc_dwdata with tap_cnt replicated into every lane (masked-off lanes = 0).
  - up_adc_dld = LANE_MASK for exactly one cycle.
  - → SETTLE.
- SETTLE: count SETTLE_CYCLES, then → CHECK.
- CHECK: clear the sample counter and timeout counter on entry; per adc_valid=1 cycle, increment the sample count.
  - adc_status=0 on a valid cycle → tap fails, → NEXT.
  - CHECK_SAMPLES good samples → tap passes; set pass_map[tap_cnt], → NEXT.
  - Timeout expiry → tap fails, → NEXT.
  - If pass and fail conditions coincide on one cycle, fail wins.
- NEXT: tap_cnt=31 → EVAL; else increment tap_cnt, → LOAD. No wrap of tap_cnt.
- EVAL: sequential scan of pass_map, one bit per cycle, 32 cycles.
  - Track run start and run length.
  - Keep the best run; only a strictly longer run replaces it, so ties go to the lowest start.
  - Windows do not wrap from tap 31 to tap 0.
  - centre = best_start + (best_len >> 1), 5-bit.
  - best_len=0 → centre = DEFAULT_TAP and set cal_fail.
- APPLY: write centre using the LOAD rules; set cal_tap = centre and cal_width = best_len.
- APPLY_SETTLE: wait SETTLE_CYCLES.
- VERIFY: each masked lane slice of up_adc_drdata must equal cal_tap; any mismatch sets cal_fail.
- DONE: one-cycle cal_done, then → IDLE; cal_busy falls in the same cycle as the return to IDLE.

Boundary conditions:
- delay_locked=0 in any state from LOAD through NEXT: return to WAIT_LOCK, clear pass_map and tap_cnt, and restart the sweep.
- Lock loss during EVAL through VERIFY is ignored.
- cal_start while busy is ignored.
- up_adc_dwdata holds its last written value between loads.
- up_adc_dld is never high for more than one consecutive cycle.

Decomposition:
- Package ad9361_cal_pkg holds:
  - the FSM state enum
  - the constants NUM_LANES=7, TAP_W=5, NUM_TAPS=32
  - the lane-slice packing function
- One natural sub-module, ad9361_cal_window, implements the EVAL scan:
  - inputs: pass_map, start
  - outputs: best_start, best_len, centre, done

Test Plan:
- Status good only at taps 10..20 → pass_map=32'h001FFC00, cal_width=11, cal_tap=15, cal_fail=0, one cal_done pulse.
- Windows 3..6 and 20..27 → cal_width=8, cal_tap=24; equal windows 2..5 and 10..13 → cal_tap=4 (the lowest start wins the tie).
- adc_status stuck 0 → pass_map=0, cal_width=0, cal_tap=DEFAULT_TAP, cal_fail=1, and a final dld pulse writing tap 0 to every lane.
- All taps pass → cal_width=32, cal_tap=16. Checker asserts 32 sweep dld pulses plus 1 apply pulse, each exactly one cycle wide with LANE_MASK set.
- Readback model corrupts lane 6 → cal_fail=1, cal_tap still equals the centre; adc_valid held low → every tap times out after TIMEOUT_CYCLES, giving pass_map=0.
- delay_locked dropped at tap 12, restored later → sweep restarts from tap 0 with pass_map cleared. In a separate run, rst_n asserted mid-CHECK → all outputs zero immediately, FSM in IDLE, and no further dld pulses.
